// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory slave port among masters, with a bus watchdog
module mem_arbiter #(
    parameter int          NUM_MASTERS = 2,
    parameter int          TIMEOUT     = 1024,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic [NUM_MASTERS-1:0]   m_sel_i,
    input  logic [32*NUM_MASTERS-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]   m_we_i,
    input  logic [4*NUM_MASTERS-1:0] m_wr_mask_i,
    input  logic [32*NUM_MASTERS-1:0] m_data_i,
    output logic [31:0]              m_data_o,
    output logic [NUM_MASTERS-1:0]   m_ack_o,
    output logic                     s_sel_o,
    output logic [31:0]              s_addr_o,
    output logic                     s_we_o,
    output logic [3:0]               s_wr_mask_o,
    output logic [31:0]              s_data_o,
    input  logic [31:0]              s_data_i,
    input  logic                     s_ack_i,
    output logic [NUM_MASTERS-1:0]   grant_o,
    output logic                     err_o,
    output logic [2:0]               err_master_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;
    logic [2:0] ptr, gidx, k, pick, gnxt;
    logic [3:0] sum;
    logic [NUM_MASTERS-1:0] rot, gnew;
    logic any, expire, done;
    logic [31:0] wd;

    assign rot  = NUM_MASTERS'({m_sel_i, m_sel_i} >> ptr);
    assign any  = |m_sel_i;
    assign gnew = NUM_MASTERS'(1) << pick;
    assign gnxt = (gidx == 3'(NUM_MASTERS - 1)) ? 3'd0 : gidx + 3'd1;

    // first requester at or after the round-robin pointer, mapped back to a master index
    always_comb begin
        k = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (rot[i]) k = 3'(i);
        sum  = {1'b0, ptr} + {1'b0, k};
        pick = (sum >= 4'(NUM_MASTERS)) ? 3'(sum - 4'(NUM_MASTERS)) : sum[2:0];
    end

    // state register
    always_ff @(posedge clk or posedge reset_i)
        if (reset_i) state <= IDLE;
        else state <= state_nxt;

    // next state: grant whenever idle with a request, release on ack or watchdog expiry
    always_comb
        state_nxt = (state == IDLE) ? (any ? BUSY : IDLE) : (done ? IDLE : BUSY);

    // completion decode and master-side responses; a real ack beats a coincident expiry
    always_comb begin
        expire   = (state == BUSY) && (TIMEOUT != 0) && !s_ack_i && (wd == 32'(TIMEOUT - 1));
        done     = (state == BUSY) && (s_ack_i || expire);
        m_ack_o  = done ? grant_o : '0;
        m_data_o = expire ? ERR_DATA : s_data_i;
    end

    // slave-side registers, grant, pointer, watchdog and error capture
    always_ff @(posedge clk or posedge reset_i)
        if (reset_i) begin
            s_sel_o      <= 1'b0;
            s_we_o       <= 1'b0;
            s_addr_o     <= '0;
            s_data_o     <= '0;
            s_wr_mask_o  <= 4'b1111;
            grant_o      <= '0;
            gidx         <= '0;
            ptr          <= '0;
            wd           <= '0;
            err_o        <= 1'b0;
            err_master_o <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                s_sel_o     <= 1'b1;
                s_addr_o    <= 32'(m_addr_i >> {pick, 5'd0});
                s_data_o    <= 32'(m_data_i >> {pick, 5'd0});
                s_wr_mask_o <= 4'(m_wr_mask_i >> {pick, 2'd0});
                s_we_o      <= |(m_we_i & gnew);
                grant_o     <= gnew;
                gidx        <= pick;
                wd          <= '0;
            end
        end else if (done) begin
            s_sel_o <= 1'b0;
            s_we_o  <= 1'b0;
            grant_o <= '0;
            ptr     <= gnxt;
            if (expire) begin
                err_o        <= 1'b1;
                err_master_o <= gidx;
            end
        end else begin
            wd <= wd + 32'd1;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized masters and slave checked against a spec-level arbitration model
module tb_mem_arbiter;
    localparam int N = 3;
    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset_i;
    logic [N-1:0] m_sel_i, m_we_i, m_ack_o, grant_o;
    logic [32*N-1:0] m_addr_i, m_data_i;
    logic [4*N-1:0] m_wr_mask_i;
    logic [31:0] m_data_o, s_addr_o, s_data_o, s_data_i;
    logic s_sel_o, s_we_o, s_ack_i, err_o;
    logic [3:0] s_wr_mask_o;
    logic [2:0] err_master_o;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset_i(reset_i),
        .m_sel_i(m_sel_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_wr_mask_i(m_wr_mask_i), .m_data_i(m_data_i),
        .m_data_o(m_data_o), .m_ack_o(m_ack_o),
        .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_wr_mask_o(s_wr_mask_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .err_o(err_o), .err_master_o(err_master_o)
    );

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: one transaction owner at a time, chosen round-robin
    bit busy, err;
    int owner, ptr, cnt, delay, err_m;
    logic [31:0] c_addr, c_data;
    logic c_we;
    logic [3:0] c_mask;
    bit [N-1:0] acked;
    int gap [N];
    bit did_rst;

    task automatic model_reset();
        busy = 0; err = 0; owner = 0; ptr = 0; cnt = 0; delay = 0; err_m = 0;
        c_addr = '0; c_data = '0; c_we = 1'b0; c_mask = 4'hF;
        acked = '0;
        for (int k = 0; k < N; k++) gap[k] = 0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (acked[k]) begin
                m_sel_i[k] = 1'b0;
                acked[k] = 1'b0;
                gap[k] = $urandom_range(1, 3);
            end else if (m_sel_i[k]) begin
                if (busy && owner == k) begin
                    if ($urandom_range(0, 1) == 1) begin
                        m_addr_i[32*k +: 32] = $urandom;
                        m_data_i[32*k +: 32] = $urandom;
                        m_we_i[k] = ~m_we_i[k];
                    end
                    if ($urandom_range(0, 39) == 0) m_sel_i[k] = 1'b0;
                end
            end else if (gap[k] > 0) begin
                gap[k]--;
            end else if (!(busy && owner == k) && $urandom_range(0, 2) == 0) begin
                m_sel_i[k] = 1'b1;
                m_addr_i[32*k +: 32] = $urandom;
                m_data_i[32*k +: 32] = $urandom;
                m_we_i[k] = 1'($urandom_range(0, 1));
                m_wr_mask_i[4*k +: 4] = 4'($urandom_range(0, 15));
            end
        end
        s_data_i = $urandom;
        s_ack_i = busy ? (cnt == delay) : ($urandom_range(0, 7) == 0);
    endtask

    task automatic check_and_step();
        bit expire, done, found;
        int nxt;
        logic [N-1:0] eack;
        expire = busy && cnt == TO - 1 && !s_ack_i;
        done = busy && (s_ack_i || expire);
        eack = done ? N'(1) << owner : '0;
        chk("s_sel", 32'(s_sel_o), 32'(busy));
        chk("grant", 32'(grant_o), busy ? 32'(N'(1) << owner) : 32'd0);
        chk("s_addr", s_addr_o, c_addr);
        chk("s_we", 32'(s_we_o), busy ? 32'(c_we) : 32'd0);
        chk("s_data", s_data_o, c_data);
        chk("s_mask", 32'(s_wr_mask_o), 32'(c_mask));
        chk("m_ack", 32'(m_ack_o), 32'(eack));
        chk("err", 32'(err_o), 32'(err));
        chk("err_master", 32'(err_master_o), 32'(err_m));
        if (eack != '0) chk("m_data", m_data_o, expire ? ERR : s_data_i);
        acked = acked | eack;
        if (!busy) begin
            found = 0;
            nxt = 0;
            for (int i = 0; i < N && !found; i++)
                if (m_sel_i[(ptr + i) % N]) begin
                    found = 1;
                    nxt = (ptr + i) % N;
                end
            if (found) begin
                busy = 1;
                owner = nxt;
                cnt = 0;
                c_addr = m_addr_i[32*nxt +: 32];
                c_data = m_data_i[32*nxt +: 32];
                c_we = m_we_i[nxt];
                c_mask = m_wr_mask_i[4*nxt +: 4];
                delay = $urandom_range(0, TO + 1);
            end
        end else if (done) begin
            busy = 0;
            ptr = (owner + 1) % N;
            if (expire) begin
                err = 1;
                err_m = owner;
            end
        end else begin
            cnt++;
        end
    endtask

    initial begin
        reset_i = 1'b1;
        m_sel_i = '0; m_we_i = '0; m_addr_i = '0; m_data_i = '0; m_wr_mask_i = '0;
        s_ack_i = 1'b0; s_data_i = '0;
        did_rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_s_sel", 32'(s_sel_o), 32'd0);
        chk("rst_s_we", 32'(s_we_o), 32'd0);
        chk("rst_s_addr", s_addr_o, 32'd0);
        chk("rst_s_data", s_data_o, 32'd0);
        chk("rst_s_mask", 32'(s_wr_mask_o), 32'hF);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_master", 32'(err_master_o), 32'd0);
        chk("rst_m_ack", 32'(m_ack_o), 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            drive_inputs();
            #2;
            if (c >= 1500 && !did_rst && busy) begin
                did_rst = 1;
                reset_i = 1'b1;
                #1;
                chk("midrst_s_sel", 32'(s_sel_o), 32'd0);
                chk("midrst_grant", 32'(grant_o), 32'd0);
                chk("midrst_m_ack", 32'(m_ack_o), 32'd0);
                m_sel_i = '0;
                s_ack_i = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                reset_i = 1'b0;
                continue;
            end
            check_and_step();
            @(posedge clk);
            #1;
        end
        if (!did_rst) chk("midrst_reached", 32'(did_rst), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
